// File: rtl/board_io_pkg.sv
// -----------------------------------------------------------------------------
// board_io_pkg
// Shared definitions for the board I/O bridge: PWM counter width, a helper
// that sizes counters able to hold the value n, and the PWM word type.
// -----------------------------------------------------------------------------
package board_io_pkg;

  localparam int PWM_W = 8;

  typedef logic [PWM_W-1:0] pwm_t;

  // Bits needed to represent 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
// One switch channel: 2-flop synchroniser, consecutive-sample debounce counter,
// accepted (stable) level and a 1-cycle change-event pulse.
// Ports:
//   clk, rst_n  board clock, asynchronous active-low reset
//   i_pin       raw asynchronous switch pin
//   o_stable    debounced level
//   o_event     1-cycle pulse on the edge o_stable changes
// -----------------------------------------------------------------------------
module sw_debounce
  import board_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_stable,
  output logic o_event
);

  localparam int             CW      = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_stable;
  logic          r_event;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_stable <= 1'b0;
      r_event  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // from before this edge; blocking would collapse the synchroniser.
      r_meta  <= i_pin;
      r_sync  <= r_meta;
      r_event <= 1'b0;
      if (r_sync != r_stable) begin
        // The sample that completes the run is the accept point; the counter
        // therefore tops out at DEBOUNCE_CYCLES-1 and never wraps.
        if (r_cnt == CNT_MAX) begin
          r_stable <= r_sync;
          r_cnt    <= '0;
          r_event  <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        // Any agreeing sample discards a partial run (glitch rejection).
        r_cnt <= '0;
      end
    end
  end

  assign o_stable = r_stable;
  assign o_event  = r_event;

endmodule

// File: rtl/board_io_bridge.sv
// -----------------------------------------------------------------------------
// board_io_bridge
// Board-side glue between FPGA pins and a SoC GPIO port.
//   - core_ce: clock enable, high one cycle in every CLK_DIV
//   - gpio_read / sw_event: synchronised, debounced switches with change pulses
//   - led_o: registered gpio_write masked by gpio_write_en
// Optional feature (macro LED_PWM_EN): 8-bit PWM brightness on led_o, duty
// taken from pwm_duty and reloaded only at the PWM period boundary.
// Ports:
//   clk, rst_n      board clock, asynchronous active-low reset
//   sw_i            raw switch pins (asynchronous)
//   gpio_read       debounced switch state
//   sw_event        per-channel 1-cycle change pulse
//   gpio_write      SoC GPIO write data (LED slice)
//   gpio_write_en   SoC GPIO write enable (LED slice)
//   pwm_duty        LED brightness (used only with LED_PWM_EN)
//   led_o           LED pins
//   core_ce         core clock enable
// -----------------------------------------------------------------------------
module board_io_bridge
  import board_io_pkg::*;
#(
  parameter int NUM_SW          = 16,
  parameter int NUM_LED         = 16,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CLK_DIV         = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SW-1:0]  sw_i,
  output logic [NUM_SW-1:0]  gpio_read,
  output logic [NUM_SW-1:0]  sw_event,
  input  logic [NUM_LED-1:0] gpio_write,
  input  logic [NUM_LED-1:0] gpio_write_en,
  input  logic [PWM_W-1:0]   pwm_duty,
  output logic [NUM_LED-1:0] led_o,
  output logic               core_ce
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (NUM_SW < 1) begin : g_bad_num_sw
    $error("board_io_bridge: NUM_SW must be >= 1");
  end
  if (NUM_LED < 1) begin : g_bad_num_led
    $error("board_io_bridge: NUM_LED must be >= 1");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("board_io_bridge: DEBOUNCE_CYCLES must be >= 1");
  end
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("board_io_bridge: CLK_DIV must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // Clock-enable divider
  // ---------------------------------------------------------------------------
  localparam int               DIV_W   = cnt_w(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic [DIV_W-1:0] w_div_nxt;
  logic             r_core_ce;

  always_comb begin
    // NOTE: a default on every path keeps this block purely combinational;
    // a missing else branch would infer a latch.
    w_div_nxt = r_div_cnt + 1'b1;
    if (r_div_cnt == DIV_MAX) begin
      w_div_nxt = '0;
    end
  end

  // core_ce is registered alongside the count (compared on the next value), so
  // it reads 0 in reset even when CLK_DIV=1 and tracks div_cnt==CLK_DIV-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_core_ce <= 1'b0;
    end else begin
      r_div_cnt <= w_div_nxt;
      r_core_ce <= (w_div_nxt == DIV_MAX);
    end
  end

  assign core_ce = r_core_ce;

  // ---------------------------------------------------------------------------
  // Switch channels
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sw_debounce (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_pin    (sw_i[g]),
      .o_stable (gpio_read[g]),
      .o_event  (sw_event[g])
    );
  end

  // ---------------------------------------------------------------------------
  // LED drive (every clk, independent of core_ce)
  // ---------------------------------------------------------------------------
  logic [NUM_LED-1:0] r_led;

`ifdef LED_PWM_EN
  localparam pwm_t PWM_MAX = '1;

  pwm_t r_pwm_cnt;
  pwm_t r_duty_q;
  logic w_pwm_on;

  assign w_pwm_on = (r_pwm_cnt < r_duty_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt <= '0;
      r_duty_q  <= '1;
      r_led     <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      // Reload only at the 255->0 wrap so a period never mixes two duties.
      if (r_pwm_cnt == PWM_MAX) begin
        r_duty_q <= pwm_duty;
      end
      r_led <= gpio_write & gpio_write_en & {NUM_LED{w_pwm_on}};
    end
  end
`else
  logic w_unused_pwm_duty;
  assign w_unused_pwm_duty = ^pwm_duty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led <= '0;
    end else begin
      r_led <= gpio_write & gpio_write_en;
    end
  end
`endif

  assign led_o = r_led;

endmodule
